// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 LSB-first UART receiver feeding a show-ahead FIFO with
// framing-error and overrun pulses.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam int AW               = $clog2(FIFO_DEPTH);
    localparam int NW               = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          full, pop, wr;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            sync  <= {sync[0], serial_in};
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == CW'(SAMPLE_TIME - 1)) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == CW'(SYMBOL_EDGE_TIME - 1)) begin
                cnt_n        = '0;
                shreg_n[idx] = rx_s;
                idx_n        = idx + 1'b1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == CW'(SYMBOL_EDGE_TIME - 1)) begin
                cnt_n   = '0;
                push    = rx_s;
                ferr    = !rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A push into a full FIFO only lands when the head is popped in the same cycle.
    assign full           = (count == NW'(FIFO_DEPTH));
    assign data_out_valid = (count != '0);
    assign pop            = data_out_valid && data_out_ready;
    assign wr             = push && (!full || pop);
    assign data_out       = mem[rd_ptr];
    assign fifo_count     = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            framing_error <= ferr;
            overrun       <= push && full && !pop;
            if (wr) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + NW'(wr) - NW'(pop);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo at 50 clk/bit.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] fifo_count;
    logic       framing_error;
    logic       overrun;

    int compared = 0;
    int mismatched = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int vcnt = 0;
    logic [7:0] popped [$];

    typedef struct {
        logic [7:0] tx;
        logic       stop_bit;
        logic [3:0] exp_count;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;
    vec_t vecs [8];

    uart_rx_fifo dut (
        .clk(clk),
        .rst_n(rst_n),
        .serial_in(serial_in),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .fifo_count(fifo_count),
        .framing_error(framing_error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (overrun) ovr_cnt++;
        if (framing_error) ferr_cnt++;
        if (data_out_valid) vcnt++;
        if (data_out_valid && data_out_ready) popped.push_back(data_out);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (50) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (50) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic drain();
        data_out_ready = 1'b1;
        repeat (14) @(negedge clk);
        data_out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_counts();
        ovr_cnt = 0;
        ferr_cnt = 0;
        vcnt = 0;
        popped.delete();
    endtask

    initial begin
        vecs[0] = '{8'h61, 1'b1, 4'd1, 8'h61, 0};
        vecs[1] = '{8'h00, 1'b1, 4'd1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 4'd1, 8'hFF, 0};
        vecs[3] = '{8'hA5, 1'b1, 4'd1, 8'hA5, 0};
        vecs[4] = '{8'h55, 1'b0, 4'd0, 8'h00, 1};
        vecs[5] = '{8'h62, 1'b1, 4'd1, 8'h62, 0};
        vecs[6] = '{8'h80, 1'b1, 4'd1, 8'h80, 0};
        vecs[7] = '{8'h01, 1'b1, 4'd1, 8'h01, 0};

        // Reset state, then a long idle line.
        repeat (3) @(negedge clk);
        check("reset_valid", data_out_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_data", data_out, 0);
        check("reset_pulses", {framing_error, overrun}, 0);
        rst_n = 1'b1;
        clear_counts();
        repeat (1000) @(negedge clk);
        check("idle_valid", data_out_valid, 0);
        check("idle_count", fifo_count, 0);
        check("idle_valid_cycles", vcnt, 0);
        check("idle_pulses", ovr_cnt + ferr_cnt, 0);

        // Single byte with consumer always ready.
        clear_counts();
        data_out_ready = 1'b1;
        send_frame(8'h61, 1'b1);
        repeat (10) @(negedge clk);
        data_out_ready = 1'b0;
        check("ready1_valid_cycles", vcnt, 1);
        check("ready1_pops", popped.size(), 1);
        if (popped.size() > 0) check("ready1_data", popped[0], 8'h61);
        check("ready1_count", fifo_count, 0);

        // Table of single frames, consumer held off until checked.
        foreach (vecs[k]) begin
            clear_counts();
            send_frame(vecs[k].tx, vecs[k].stop_bit);
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_count", k), fifo_count, vecs[k].exp_count);
            if (vecs[k].exp_count != 0) check($sformatf("vec%0d_data", k), data_out, vecs[k].exp_data);
            check($sformatf("vec%0d_ferr", k), ferr_cnt, vecs[k].exp_ferr);
            drain();
        end

        // Ten back-to-back bytes with no consumer: saturate and overrun twice.
        clear_counts();
        for (int i = 0; i < 10; i++) send_frame(8'h61 + 8'(i), 1'b1);
        repeat (10) @(negedge clk);
        check("burst_count", fifo_count, 8);
        check("burst_overruns", ovr_cnt, 2);
        check("burst_ferr", ferr_cnt, 0);
        drain();
        check("burst_drain_n", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check($sformatf("burst_drain%0d", i), popped[i], 8'h61 + 8'(i));
        check("burst_empty", fifo_count, 0);

        // Short low glitch on idle line is rejected; following frame still decodes.
        clear_counts();
        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_count", fifo_count, 0);
        check("glitch_valid_cycles", vcnt, 0);
        check("glitch_ferr", ferr_cnt, 0);
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check("post_glitch_data", data_out, 8'hA5);
        check("post_glitch_count", fifo_count, 1);
        drain();

        // Framing error followed by a held-low break, then a clean frame.
        clear_counts();
        send_frame(8'h55, 1'b0);
        serial_in = 1'b0;
        repeat (300) @(negedge clk);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        check("break_ferr", ferr_cnt, 1);
        check("break_count", fifo_count, 0);
        send_frame(8'h62, 1'b1);
        repeat (10) @(negedge clk);
        check("after_break_count", fifo_count, 1);
        check("after_break_data", data_out, 8'h62);
        check("after_break_ferr", ferr_cnt, 1);
        drain();

        // Full FIFO: the 9th byte's push lands on the same edge as a pop.
        clear_counts();
        for (int i = 0; i < 8; i++) send_frame(8'h61 + 8'(i), 1'b1);
        repeat (5) @(negedge clk);
        check("coinc_full", fifo_count, 8);
        fork
            send_frame(8'h71, 1'b1);
            begin
                repeat (477) @(negedge clk);
                data_out_ready = 1'b1;
                @(negedge clk);
                data_out_ready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("coinc_count", fifo_count, 8);
        check("coinc_overrun", ovr_cnt, 0);
        check("coinc_pops", popped.size(), 1);
        drain();
        check("coinc_total", popped.size(), 9);
        for (int i = 0; i < 9 && i < popped.size(); i++)
            check($sformatf("coinc_order%0d", i), popped[i], (i < 8) ? 8'h61 + 8'(i) : 8'h71);

        // Reset in the middle of a frame with three bytes buffered.
        clear_counts();
        for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 1'b1);
        repeat (5) @(negedge clk);
        check("prereset_count", fifo_count, 3);
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        serial_in = 1'b1;
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", data_out_valid, 0);
        check("midreset_count", fifo_count, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_counts();
        send_frame(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        check("postreset_count", fifo_count, 1);
        check("postreset_data", data_out, 8'hC3);
        check("postreset_pulses", ovr_cnt + ferr_cnt, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
